// File: rtl/rs_age_ordered.sv
// rs_age_ordered: age-ordered reservation station for the integer ALU pipe.
// Entries capture operands at dispatch (with same-cycle CDB bypass), wake on
// any of NUM_CDB broadcast channels, and the oldest ready entry (by ROB age
// relative to rob_head_id) issues through a registered output stage.
// Optional feature macro: RS_PARTIAL_FLUSH_EN (adds flush_tag; flush then
// only removes entries younger than flush_tag).
//
// Output handshake: a transfer happens on a clock edge where out_valid and
// out_ready are both high (and rdy is high). While out_valid is high and
// out_ready is low, out_op/out_tag/out_val1/out_val2 do not change, and
// out_valid only drops after a completed transfer or a flush.
module rs_age_ordered #(
    parameter int RS_DEPTH  = 8,
    parameter int XLEN      = 32,
    parameter int TAG_WIDTH = 4,
    parameter int NUM_CDB   = 2,
    parameter int OP_WIDTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rdy,
    input  logic                          flush,
`ifdef RS_PARTIAL_FLUSH_EN
    input  logic [TAG_WIDTH-1:0]          flush_tag,
`endif
    input  logic [TAG_WIDTH-1:0]          rob_head_id,
    input  logic                          disp_valid,
    input  logic [OP_WIDTH-1:0]           disp_op,
    input  logic [TAG_WIDTH-1:0]          disp_tag,
    input  logic                          disp_q1_valid,
    input  logic [TAG_WIDTH-1:0]          disp_q1,
    input  logic [XLEN-1:0]               disp_v1,
    input  logic                          disp_q2_valid,
    input  logic [TAG_WIDTH-1:0]          disp_q2,
    input  logic [XLEN-1:0]               disp_v2,
    input  logic [NUM_CDB-1:0]            cdb_valid,
    input  logic [NUM_CDB*TAG_WIDTH-1:0]  cdb_tag,
    input  logic [NUM_CDB*XLEN-1:0]       cdb_data,
    output logic                          rs_full,
    output logic [$clog2(RS_DEPTH+1)-1:0] rs_count,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OP_WIDTH-1:0]           out_op,
    output logic [XLEN-1:0]               out_val1,
    output logic [XLEN-1:0]               out_val2,
    output logic [TAG_WIDTH-1:0]          out_tag
);

    localparam int IDX_W = $clog2(RS_DEPTH);
    localparam int CNT_W = $clog2(RS_DEPTH + 1);

    // Entry storage
    logic [RS_DEPTH-1:0]  ent_busy;
    logic [OP_WIDTH-1:0]  ent_op       [RS_DEPTH];
    logic [TAG_WIDTH-1:0] ent_tag      [RS_DEPTH];
    logic [RS_DEPTH-1:0]  ent_q1_valid;
    logic [TAG_WIDTH-1:0] ent_q1       [RS_DEPTH];
    logic [XLEN-1:0]      ent_v1       [RS_DEPTH];
    logic [RS_DEPTH-1:0]  ent_q2_valid;
    logic [TAG_WIDTH-1:0] ent_q2       [RS_DEPTH];
    logic [XLEN-1:0]      ent_v2       [RS_DEPTH];

    logic [CNT_W-1:0]     count_q;

    // Derived per-entry state
    logic [RS_DEPTH-1:0]  ent_ready;
    logic [TAG_WIDTH-1:0] ent_age      [RS_DEPTH];
    logic [RS_DEPTH-1:0]  wake_q1_valid;
    logic [XLEN-1:0]      wake_v1      [RS_DEPTH];
    logic [RS_DEPTH-1:0]  wake_q2_valid;
    logic [XLEN-1:0]      wake_v2      [RS_DEPTH];

    // Dispatch-side operand resolution
    logic                 byp_q1_valid;
    logic [XLEN-1:0]      byp_v1;
    logic                 byp_q2_valid;
    logic [XLEN-1:0]      byp_v2;

    // Select / allocate / flush
    logic                 sel_found;
    logic [IDX_W-1:0]     sel_idx;
    logic [TAG_WIDTH-1:0] sel_age;
    logic                 free_found;
    logic [IDX_W-1:0]     free_idx;
    logic [RS_DEPTH-1:0]  kill;
    logic                 out_kill;
    logic [RS_DEPTH-1:0]  survivors;
    logic [CNT_W-1:0]     survivor_count;

    logic                 disp_fire;
    logic                 issue_fire;
    logic [RS_DEPTH-1:0]  next_busy;
    logic [CNT_W-1:0]     next_count;

    assign rs_count   = count_q;
    assign rs_full    = (count_q == CNT_W'(RS_DEPTH));
    assign disp_fire  = disp_valid && !rs_full && !flush;
    assign issue_fire = !flush && (!out_valid || out_ready) && sel_found;

    // Readiness and age of each entry from registered state
    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            ent_ready[i] = ent_busy[i] && !ent_q1_valid[i] && !ent_q2_valid[i];
            ent_age[i]   = ent_tag[i] - rob_head_id;
        end
    end

    // Wakeup: descending channel loop so the lowest matching channel wins
    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            wake_q1_valid[i] = ent_q1_valid[i];
            wake_v1[i]       = ent_v1[i];
            wake_q2_valid[i] = ent_q2_valid[i];
            wake_v2[i]       = ent_v2[i];
            for (int k = NUM_CDB - 1; k >= 0; k--) begin
                if (ent_busy[i] && cdb_valid[k] && ent_q1_valid[i] &&
                    ent_q1[i] == cdb_tag[k*TAG_WIDTH +: TAG_WIDTH]) begin
                    wake_q1_valid[i] = 1'b0;
                    wake_v1[i]       = cdb_data[k*XLEN +: XLEN];
                end
                if (ent_busy[i] && cdb_valid[k] && ent_q2_valid[i] &&
                    ent_q2[i] == cdb_tag[k*TAG_WIDTH +: TAG_WIDTH]) begin
                    wake_q2_valid[i] = 1'b0;
                    wake_v2[i]       = cdb_data[k*XLEN +: XLEN];
                end
            end
        end
    end

    // Dispatch bypass: resolve pending dispatch operands from this cycle's CDB
    always_comb begin
        byp_q1_valid = disp_q1_valid;
        byp_v1       = disp_v1;
        byp_q2_valid = disp_q2_valid;
        byp_v2       = disp_v2;
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (cdb_valid[k] && disp_q1_valid &&
                disp_q1 == cdb_tag[k*TAG_WIDTH +: TAG_WIDTH]) begin
                byp_q1_valid = 1'b0;
                byp_v1       = cdb_data[k*XLEN +: XLEN];
            end
            if (cdb_valid[k] && disp_q2_valid &&
                disp_q2 == cdb_tag[k*TAG_WIDTH +: TAG_WIDTH]) begin
                byp_q2_valid = 1'b0;
                byp_v2       = cdb_data[k*XLEN +: XLEN];
            end
        end
    end

    // Oldest-ready select; strict compare keeps the lower index on equal age
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_age   = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (ent_ready[i] && (!sel_found || ent_age[i] < sel_age)) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
                sel_age   = ent_age[i];
            end
        end
    end

    // Lowest-index free entry for dispatch
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (!free_found && !ent_busy[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

`ifdef RS_PARTIAL_FLUSH_EN
    logic [TAG_WIDTH-1:0] flush_age;
    logic [TAG_WIDTH-1:0] out_age;

    // Partial flush: only entries younger than flush_tag are removed
    always_comb begin
        flush_age = flush_tag - rob_head_id;
        out_age   = out_tag - rob_head_id;
        out_kill  = (out_age > flush_age);
        for (int i = 0; i < RS_DEPTH; i++) begin
            kill[i] = ent_busy[i] && (ent_age[i] > flush_age);
        end
    end
`else
    // Full flush: every entry and the output stage are removed
    always_comb begin
        kill     = ent_busy;
        out_kill = 1'b1;
    end
`endif

    // Occupancy after a flush, counted from the surviving entries
    always_comb begin
        survivors      = ent_busy & ~kill;
        survivor_count = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (survivors[i]) survivor_count = survivor_count + CNT_W'(1);
        end
    end

    // Next busy vector and occupancy count
    always_comb begin
        next_busy  = ent_busy;
        next_count = count_q;
        if (flush) begin
            next_busy  = survivors;
            next_count = survivor_count;
        end else begin
            if (issue_fire) next_busy[sel_idx] = 1'b0;
            if (disp_fire)  next_busy[free_idx] = 1'b1;
            case ({disp_fire, issue_fire})
                2'b10:   next_count = count_q + CNT_W'(1);
                2'b01:   next_count = count_q - CNT_W'(1);
                default: next_count = count_q;
            endcase
        end
    end

    // Entry state register: wakeups every cycle, dispatch overwrites its slot
    always_ff @(posedge clk) begin
        if (rst) begin
            ent_busy     <= '0;
            ent_q1_valid <= '0;
            ent_q2_valid <= '0;
            count_q      <= '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                ent_op[i]  <= '0;
                ent_tag[i] <= '0;
                ent_q1[i]  <= '0;
                ent_v1[i]  <= '0;
                ent_q2[i]  <= '0;
                ent_v2[i]  <= '0;
            end
        end else if (rdy) begin
            ent_busy     <= next_busy;
            count_q      <= next_count;
            ent_q1_valid <= wake_q1_valid;
            ent_q2_valid <= wake_q2_valid;
            for (int i = 0; i < RS_DEPTH; i++) begin
                ent_v1[i] <= wake_v1[i];
                ent_v2[i] <= wake_v2[i];
            end
            if (disp_fire) begin
                ent_op[free_idx]       <= disp_op;
                ent_tag[free_idx]      <= disp_tag;
                ent_q1_valid[free_idx] <= byp_q1_valid;
                ent_q1[free_idx]       <= disp_q1;
                ent_v1[free_idx]       <= byp_v1;
                ent_q2_valid[free_idx] <= byp_q2_valid;
                ent_q2[free_idx]       <= disp_q2;
                ent_v2[free_idx]       <= byp_v2;
            end
        end
    end

    // Registered issue stage toward the ALU
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_op    <= '0;
            out_tag   <= '0;
            out_val1  <= '0;
            out_val2  <= '0;
        end else if (rdy) begin
            if (flush) begin
                out_valid <= out_valid && !out_ready && !out_kill;
            end else if (issue_fire) begin
                out_valid <= 1'b1;
                out_op    <= ent_op[sel_idx];
                out_tag   <= ent_tag[sel_idx];
                out_val1  <= ent_v1[sel_idx];
                out_val2  <= ent_v2[sel_idx];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rs_age_ordered.sv
// tb_rs_age_ordered: directed bench for rs_age_ordered. Expected issues are
// queued as stimulus is applied; a negedge monitor pops and compares each
// completed output transfer. Direct checks cover count/full/valid timing.
module tb_rs_age_ordered;

    localparam int RS_DEPTH  = 8;
    localparam int XLEN      = 32;
    localparam int TAG_WIDTH = 4;
    localparam int NUM_CDB   = 2;
    localparam int OP_WIDTH  = 4;
    localparam int CNT_W     = 4;
    localparam int W         = OP_WIDTH + TAG_WIDTH + 2 * XLEN;

    logic                         clk;
    logic                         rst;
    logic                         rdy;
    logic                         flush;
    logic [TAG_WIDTH-1:0]         flush_tag;
    logic [TAG_WIDTH-1:0]         rob_head_id;
    logic                         disp_valid;
    logic [OP_WIDTH-1:0]          disp_op;
    logic [TAG_WIDTH-1:0]         disp_tag;
    logic                         disp_q1_valid;
    logic [TAG_WIDTH-1:0]         disp_q1;
    logic [XLEN-1:0]              disp_v1;
    logic                         disp_q2_valid;
    logic [TAG_WIDTH-1:0]         disp_q2;
    logic [XLEN-1:0]              disp_v2;
    logic [NUM_CDB-1:0]           cdb_valid;
    logic [NUM_CDB*TAG_WIDTH-1:0] cdb_tag;
    logic [NUM_CDB*XLEN-1:0]      cdb_data;
    logic                         rs_full;
    logic [CNT_W-1:0]             rs_count;
    logic                         out_valid;
    logic                         out_ready;
    logic [OP_WIDTH-1:0]          out_op;
    logic [XLEN-1:0]              out_val1;
    logic [XLEN-1:0]              out_val2;
    logic [TAG_WIDTH-1:0]         out_tag;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    rs_age_ordered #(
        .RS_DEPTH(RS_DEPTH), .XLEN(XLEN), .TAG_WIDTH(TAG_WIDTH),
        .NUM_CDB(NUM_CDB), .OP_WIDTH(OP_WIDTH)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
`ifdef RS_PARTIAL_FLUSH_EN
        .flush_tag(flush_tag),
`endif
        .rob_head_id(rob_head_id),
        .disp_valid(disp_valid), .disp_op(disp_op), .disp_tag(disp_tag),
        .disp_q1_valid(disp_q1_valid), .disp_q1(disp_q1), .disp_v1(disp_v1),
        .disp_q2_valid(disp_q2_valid), .disp_q2(disp_q2), .disp_v2(disp_v2),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .rs_full(rs_full), .rs_count(rs_count),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
        .out_val1(out_val1), .out_val2(out_val2), .out_tag(out_tag)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [3:0] op, input logic [3:0] tag,
                            input logic [31:0] v1, input logic [31:0] v2);
        exp_q.push_back({op, tag, v1, v2});
    endtask

    task automatic disp(input logic [3:0] op, input logic [3:0] tag,
                        input logic q1v, input logic [3:0] q1, input logic [31:0] v1,
                        input logic q2v, input logic [3:0] q2, input logic [31:0] v2);
        disp_valid    = 1'b1;
        disp_op       = op;
        disp_tag      = tag;
        disp_q1_valid = q1v;
        disp_q1       = q1;
        disp_v1       = v1;
        disp_q2_valid = q2v;
        disp_q2       = q2;
        disp_v2       = v2;
        tick();
        disp_valid    = 1'b0;
    endtask

    task automatic set_cdb(input int ch, input logic [3:0] tag, input logic [31:0] data);
        cdb_valid = '0;
        cdb_valid[ch] = 1'b1;
        cdb_tag[ch*TAG_WIDTH +: TAG_WIDTH] = tag;
        cdb_data[ch*XLEN +: XLEN] = data;
    endtask

    // Scoreboard monitor: compare every completed output transfer
    always @(negedge clk) begin
        logic [W-1:0] exp;
        if (!rst && rdy && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL issue_unexpected: got tag %0h op %0h v1 %0h v2 %0h, none expected",
                         out_tag, out_op, out_val1, out_val2);
            end else begin
                exp = exp_q.pop_front();
                if ({out_op, out_tag, out_val1, out_val2} !== exp) begin
                    errors++;
                    $display("FAIL issue_data: got op %0h tag %0h v1 %0h v2 %0h expected op %0h tag %0h v1 %0h v2 %0h",
                             out_op, out_tag, out_val1, out_val2,
                             exp[W-1 -: 4], exp[W-5 -: 4], exp[63:32], exp[31:0]);
                end
            end
        end
    end

    // Directed stimulus
    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; flush_tag = '0; rob_head_id = '0;
        disp_valid = 1'b0; disp_op = '0; disp_tag = '0;
        disp_q1_valid = 1'b0; disp_q1 = '0; disp_v1 = '0;
        disp_q2_valid = 1'b0; disp_q2 = '0; disp_v2 = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_data = '0; out_ready = 1'b0;
        repeat (3) tick();

        // Reset state
        check("reset_count", 64'(rs_count), 64'd0);
        check("reset_full", 64'(rs_full), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_tag", 64'(out_tag), 64'd0);
        check("reset_out_val1", 64'(out_val1), 64'd0);
        rst = 1'b0;
        tick();

        // 1: minimum latency, both operands ready
        out_ready = 1'b1;
        push_exp(4'h1, 4'd3, 32'd5, 32'd7);
        disp(4'h1, 4'd3, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd7);
        check("t1_count_after_disp", 64'(rs_count), 64'd1);
        check("t1_valid_edge_n", 64'(out_valid), 64'd0);
        tick();
        check("t1_valid_edge_n1", 64'(out_valid), 64'd1);
        check("t1_out_tag", 64'(out_tag), 64'd3);
        check("t1_count_after_issue", 64'(rs_count), 64'd0);
        tick();
        check("t1_valid_drop", 64'(out_valid), 64'd0);

        // rdy low: dispatch has no effect
        rdy = 1'b0;
        disp(4'h2, 4'd9, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd1);
        rdy = 1'b1;
        check("rdy_low_count", 64'(rs_count), 64'd0);
        check("rdy_low_valid", 64'(out_valid), 64'd0);

        // 2: age order with rob_head_id = 14; a first tag-13 issue holds the output
        out_ready = 1'b0;
        rob_head_id = 4'd14;
        push_exp(4'h3, 4'd13, 32'h13, 32'h31);
        push_exp(4'h6, 4'd14, 32'h14, 32'h41);
        push_exp(4'h5, 4'd15, 32'h15, 32'h51);
        push_exp(4'h4, 4'd1, 32'h01, 32'h10);
        disp(4'h3, 4'd13, 1'b0, 4'd0, 32'h13, 1'b0, 4'd0, 32'h31);
        tick();
        disp(4'h4, 4'd1, 1'b0, 4'd0, 32'h01, 1'b0, 4'd0, 32'h10);
        disp(4'h5, 4'd15, 1'b0, 4'd0, 32'h15, 1'b0, 4'd0, 32'h51);
        disp(4'h6, 4'd14, 1'b0, 4'd0, 32'h14, 1'b0, 4'd0, 32'h41);
        check("t2_count", 64'(rs_count), 64'd3);
        check("t2_hold_tag", 64'(out_tag), 64'd13);
        out_ready = 1'b1;
        repeat (6) tick();
        check("t2_drained_count", 64'(rs_count), 64'd0);
        check("t2_drained_valid", 64'(out_valid), 64'd0);

        // 3: wakeup on channel 1, then dispatch bypass on channel 0
        rob_head_id = 4'd0;
        disp(4'h7, 4'd2, 1'b1, 4'd6, 32'h0, 1'b0, 4'd0, 32'h11);
        repeat (2) tick();
        check("t3_waiting_valid", 64'(out_valid), 64'd0);
        check("t3_waiting_count", 64'(rs_count), 64'd1);
        push_exp(4'h7, 4'd2, 32'hDEAD, 32'h11);
        set_cdb(1, 4'd6, 32'hDEAD);
        tick();
        cdb_valid = '0;
        check("t3_wake_edge_valid", 64'(out_valid), 64'd0);
        tick();
        check("t3_issue_valid", 64'(out_valid), 64'd1);
        check("t3_issue_val1", 64'(out_val1), 64'hDEAD);
        tick();
        push_exp(4'h8, 4'd4, 32'h22, 32'hBEEF);
        set_cdb(0, 4'd7, 32'hBEEF);
        disp(4'h8, 4'd4, 1'b0, 4'd0, 32'h22, 1'b1, 4'd7, 32'h0);
        cdb_valid = '0;
        tick();
        check("t3_bypass_valid", 64'(out_valid), 64'd1);
        check("t3_bypass_val2", 64'(out_val2), 64'hBEEF);
        tick();

        // 4: fill with pending entries tags 8..1, then full-edge dispatch drops
        out_ready = 1'b0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            disp(4'(8 - i), 4'(8 - i), 1'b1, 4'd9, 32'h0, 1'b0, 4'd0, 32'h50 + 32'(8 - i));
        end
        check("t4_full", 64'(rs_full), 64'd1);
        check("t4_count_full", 64'(rs_count), 64'd8);
        disp(4'hA, 4'd0, 1'b0, 4'd0, 32'hE0, 1'b0, 4'd0, 32'hE1);
        check("t4_drop_while_full", 64'(rs_count), 64'd8);
        push_exp(4'd1, 4'd1, 32'h100, 32'h51);
        set_cdb(0, 4'd9, 32'h100);
        tick();
        cdb_valid = '0;
        disp(4'hA, 4'd0, 1'b0, 4'd0, 32'hE0, 1'b0, 4'd0, 32'hE1);
        check("t4_count_issue_drop", 64'(rs_count), 64'd7);
        check("t4_not_full", 64'(rs_full), 64'd0);
        check("t4_out_tag", 64'(out_tag), 64'd1);

        // 5: backpressure while an older entry becomes ready
        push_exp(4'hB, 4'd0, 32'hA0, 32'hB0);
        for (int t = 2; t <= 8; t++) push_exp(4'(t), 4'(t), 32'h100, 32'h50 + 32'(t));
        disp(4'hB, 4'd0, 1'b0, 4'd0, 32'hA0, 1'b0, 4'd0, 32'hB0);
        for (int c = 0; c < 5; c++) begin
            check("t5_hold_valid", 64'(out_valid), 64'd1);
            check("t5_hold_tag", 64'(out_tag), 64'd1);
            check("t5_hold_val", {out_val1, out_val2}, {32'h100, 32'h51});
            tick();
        end
        out_ready = 1'b1;
        repeat (12) tick();
        check("t5_drained_count", 64'(rs_count), 64'd0);
        check("t5_drained_valid", 64'(out_valid), 64'd0);

        // 6: flush with 4 busy entries, held output and a concurrent dispatch
        out_ready = 1'b0;
        disp(4'hF, 4'd0, 1'b0, 4'd0, 32'h77, 1'b0, 4'd0, 32'h88);
        tick();
        check("t6_out_held", 64'(out_valid), 64'd1);
        disp(4'd1, 4'd1, 1'b1, 4'd9, 32'h0, 1'b0, 4'd0, 32'h61);
        disp(4'd2, 4'd2, 1'b1, 4'd9, 32'h0, 1'b0, 4'd0, 32'h62);
        disp(4'd3, 4'd3, 1'b1, 4'd9, 32'h0, 1'b0, 4'd0, 32'h63);
        disp(4'd5, 4'd5, 1'b1, 4'd9, 32'h0, 1'b0, 4'd0, 32'h65);
        check("t6_count_before", 64'(rs_count), 64'd4);
        flush = 1'b1;
        flush_tag = 4'd2;
        set_cdb(0, 4'd9, 32'h200);
        disp(4'hC, 4'd6, 1'b0, 4'd0, 32'hC0, 1'b0, 4'd0, 32'hC1);
        flush = 1'b0;
        cdb_valid = '0;
`ifdef RS_PARTIAL_FLUSH_EN
        check("t6_partial_count", 64'(rs_count), 64'd2);
        check("t6_partial_valid", 64'(out_valid), 64'd1);
        check("t6_partial_tag", 64'(out_tag), 64'd0);
        push_exp(4'hF, 4'd0, 32'h77, 32'h88);
        push_exp(4'd1, 4'd1, 32'h200, 32'h61);
        push_exp(4'd2, 4'd2, 32'h200, 32'h62);
`else
        check("t6_flush_count", 64'(rs_count), 64'd0);
        check("t6_flush_valid", 64'(out_valid), 64'd0);
        check("t6_flush_full", 64'(rs_full), 64'd0);
`endif
        set_cdb(0, 4'd9, 32'h300);
        tick();
        cdb_valid = '0;
        out_ready = 1'b1;
        repeat (8) tick();
        check("t6_end_count", 64'(rs_count), 64'd0);
        check("t6_end_valid", 64'(out_valid), 64'd0);

        // Final report
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rs_age_ordered.md
Name: rs_age_ordered

Overview:
Parametrised reservation station for the integer ALU pipe of the Tomasulo core. It accepts pre-decoded ALU ops from dispatch and captures operands from the register file, ROB or any of NUM_CDB broadcast buses. It wakes waiting operands from those buses and issues the oldest ready entry, by ROB age, through a registered valid/ready output to the ALU. Successor to the single-CDB, first-free-index station: adds configurable depth, multiple wakeup channels, age-ordered select and ALU backpressure.

Parameters:
RS_DEPTH, 8, number of entries (>=2)
XLEN, 32, operand width
TAG_WIDTH, 4, ROB id width
NUM_CDB, 2, number of result broadcast channels
OP_WIDTH, 4, ALU op code width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; when low, all state holds
flush  in  1  pipeline flush
rob_head_id  in  TAG_WIDTH  oldest in-flight ROB id, used as the age reference
disp_valid  in  1  dispatch request
disp_op  in  OP_WIDTH  ALU op
disp_tag  in  TAG_WIDTH  ROB id of the dispatched inst
disp_q1_valid  in  1  operand 1 still pending
disp_q1  in  TAG_WIDTH  producer tag of operand 1
disp_v1  in  XLEN  operand 1 value when not pending
disp_q2_valid, disp_q2, disp_v2  in  1/TAG_WIDTH/XLEN  same for operand 2 (immediate already muxed in)
cdb_valid  in  NUM_CDB  per-channel broadcast valid
cdb_tag  in  NUM_CDB*TAG_WIDTH  packed tags; channel k at [k*TAG_WIDTH +: TAG_WIDTH]
cdb_data  in  NUM_CDB*XLEN  packed results
rs_full  out  1  no free entry
rs_count  out  $clog2(RS_DEPTH+1)  occupied entries
out_valid  out  1  issue valid to ALU
out_ready  in  1  ALU accepts
out_op  out  OP_WIDTH  issued op
out_val1, out_val2  out  XLEN  issued operands
out_tag  out  TAG_WIDTH  issued ROB id

Behaviour:
- Reset: all entries invalid; rs_count=0, rs_full=0, out_valid=0, out_op/out_val1/out_val2/out_tag=0. rst has priority over rdy and flush.
- rdy low: no state changes; outputs hold.
- Entry fields: busy, op, tag, q1_valid, q1, v1, q2_valid, q2, v2.
- Dispatch: accepted on an edge when disp_valid && !rs_full && !flush. Written into the lowest-index free entry.
- Dispatch is ignored when rs_full, even if an issue frees a slot on the same edge. rs_full and rs_count are registered-state derived. Upstream must gate disp_valid with rs_full.
- Dispatch bypass: a pending disp operand whose tag matches a valid CDB channel that cycle is stored resolved with that channel's data.
- Wakeup: every busy entry with q*_valid and a tag matching valid channel k clears q*_valid and latches cdb_data[k] on the edge.
- If several channels match the same tag, the lowest k wins; this is not legal upstream.
- Ready entry: busy && !q1_valid && !q2_valid, evaluated on registered state. An operand woken at edge N makes the entry selectable in cycle N+1.
- Age: (tag - rob_head_id) mod 2^TAG_WIDTH; smaller is older.
- Select: the oldest ready entry; on equal age, the lower index wins.
- Issue: when (!out_valid || out_ready) and a ready entry exists, the output registers load that entry and the entry is freed on the same edge. Otherwise, out_valid falls if out_ready was high, or holds.
- While out_valid && !out_ready, all out_* outputs stay stable.
- Minimum latency: dispatch with both operands ready at edge N gives out_valid=1 after edge N+1.
- Back-to-back: with out_ready held high, one issue per cycle.
- rs_count: +1 on accepted dispatch, -1 on issue; both on the same edge leaves it unchanged. rs_full = (rs_count == RS_DEPTH).
- Flush (without optional feature): all busy cleared and out_valid=0 on the edge; same-edge dispatch and wakeups are discarded; rs_count=0.

Optional Feature:
RS_PARTIAL_FLUSH_EN. When defined, adds input flush_tag [TAG_WIDTH].
- On flush, only entries with age(tag) > age(flush_tag) are cleared.
- out_valid is cleared only if age(out_tag) > age(flush_tag).
- Surviving entries still accept same-edge wakeups.
- rs_count is recomputed from the survivors, with same-edge dispatch rejected.
When undefined, there is no flush_tag port and flush clears everything.

Test Plan:
1. Reset, then dispatch op=ADD, tag=3, v1=5, v2=7 (both ready), out_ready=1 -> out_valid=1 two edges later with out_val1=5, out_val2=7, out_tag=3; then out_valid=0 and rs_count=0.
2. Age order: rob_head_id=14; dispatch ready tags 1, 15, 14 into entries 0/1/2 with out_ready=0, then raise out_ready -> issue order 14, 15, 1.
3. Wakeup: entry waiting q1=6; cdb_valid=2'b10, cdb_tag[ch1]=6, cdb_data[ch1]=0xDEAD -> issues next cycle with out_val1=0xDEAD. Also, the same tag on the dispatch-cycle CDB -> stored resolved (bypass).
4. Fill to RS_DEPTH=8 -> rs_full=1. Dispatch on the same edge as an issue -> dispatch dropped, rs_count=7.
5. Backpressure: out_valid=1 with out_ready=0 for 5 cycles while a newer older-tag entry becomes ready -> out_tag/out_val* unchanged until out_ready=1.
6. Flush with 4 busy entries and out_valid=1 plus a concurrent dispatch -> next cycle rs_count=0, out_valid=0. With RS_PARTIAL_FLUSH_EN, rob_head_id=0, flush_tag=2 and entries tagged 1, 2, 3, 5 -> entries 1 and 2 remain, rs_count=2.
